// File: rtl/genius_control.sv
// Moore control FSM for the GENIUS game; drives datapath enables/resets and SEL from the state register.
// Latency: ENTER_N to enter_p is SYNC_STAGES+1 cycles; status flags act on the next clock edge.
// Backpressure: none; the FSM simply waits in SETUP/PLAY_*/RESULT for the status flag or key press.
// Optional macro GENIUS_AUTO_RESTART_EN adds a RESULT dwell counter that returns to INIT automatically.
module genius_control #(
  parameter int SYNC_STAGES    = 2,
  parameter int RESTART_CYCLES = 250000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       ENTER_N,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    INIT        = 3'b000,
    SETUP       = 3'b001,
    START_ROUND = 3'b010,
    PLAY_FPGA   = 3'b011,
    PLAY_USER   = 3'b100,
    CHECK       = 3'b101,
    NEXT_ROUND  = 3'b110,
    RESULT      = 3'b111
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   enter_p;
  logic                   dwell_done;

  // Synchronize the raw key and turn each press (falling edge) into a single registered pulse.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      edge_q  <= 1'b1;
      enter_p <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ENTER_N};
      edge_q  <= sync_q[SYNC_STAGES-1];
      enter_p <= edge_q & ~sync_q[SYNC_STAGES-1];
    end
  end

`ifdef GENIUS_AUTO_RESTART_EN
  localparam int CW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

  logic [CW-1:0] dwell_q;

  assign dwell_done = (state_q == RESULT) && (dwell_q == CW'(RESTART_CYCLES - 1));

  // Count cycles spent in RESULT; held at zero everywhere else so every entry starts fresh.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q <= '0;
    end else if (state_q == RESULT && !dwell_done) begin
      dwell_q <= dwell_q + 1'b1;
    end else begin
      dwell_q <= '0;
    end
  end
`else
  assign dwell_done = 1'b0;
`endif

  // Game sequencing; all eight codes are legal states so no recovery path is needed.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
    end else begin
      case (state_q)
        INIT:        state_q <= SETUP;
        SETUP:       if (enter_p) state_q <= START_ROUND;
        START_ROUND: state_q <= PLAY_FPGA;
        PLAY_FPGA:   if (end_FPGA) state_q <= PLAY_USER;
        PLAY_USER: begin
          // A completed entry wins over a timeout arriving in the same cycle.
          if (end_User)      state_q <= CHECK;
          else if (end_time) state_q <= RESULT;
        end
        CHECK: begin
          if (match && !win) state_q <= NEXT_ROUND;
          else               state_q <= RESULT;
        end
        NEXT_ROUND:  state_q <= START_ROUND;
        RESULT:      if (enter_p || dwell_done) state_q <= INIT;
        default:     state_q <= INIT;
      endcase
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    E4  = 1'b0;
    SEL = 1'b1;
    case (state_q)
      INIT: begin
        R1 = 1'b1;
        R2 = 1'b1;
      end
      SETUP:       E1  = 1'b1;
      START_ROUND: R2  = 1'b1;
      PLAY_FPGA:   E3  = 1'b1;
      PLAY_USER:   E2  = 1'b1;
      CHECK:       SEL = 1'b1;
      NEXT_ROUND:  E4  = 1'b1;
      RESULT:      SEL = 1'b0;
      default:     SEL = 1'b1;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_genius_control.sv
// Directed bench for genius_control: walks the game FSM through every state and transition.
// Latency: outputs sampled 1 ns after each rising edge; inputs driven at the same point.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_genius_control;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ENTER_N  = 1'b1;
  logic       end_FPGA = 1'b0;
  logic       end_User = 1'b0;
  logic       end_time = 1'b0;
  logic       win      = 1'b0;
  logic       match    = 1'b0;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state_o;
  logic [9:0] outs;

  int total = 0;
  int bad   = 0;

  // {state_o, R1, R2, E1, E2, E3, E4, SEL}
  localparam logic [9:0] O_INIT   = 10'b000_1_1_0000_1;
  localparam logic [9:0] O_SETUP  = 10'b001_0_0_1000_1;
  localparam logic [9:0] O_START  = 10'b010_0_1_0000_1;
  localparam logic [9:0] O_PLAYF  = 10'b011_0_0_0010_1;
  localparam logic [9:0] O_PLAYU  = 10'b100_0_0_0100_1;
  localparam logic [9:0] O_CHECK  = 10'b101_0_0_0000_1;
  localparam logic [9:0] O_NEXT   = 10'b110_0_0_0001_1;
  localparam logic [9:0] O_RESULT = 10'b111_0_0_0000_0;

  genius_control #(.SYNC_STAGES(2), .RESTART_CYCLES(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .ENTER_N  (ENTER_N),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .state_o  (state_o)
  );

  assign outs = {state_o, R1, R2, E1, E2, E3, E4, SEL};

  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance one clock and also confirm the enables are never simultaneously active.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    total++;
    if ($countones({E1, E2, E3, E4}) > 1) begin
      bad++;
      $display("FAIL enable_onehot got=%b want=at most one set", {E1, E2, E3, E4});
    end
  endtask

  // Release, let the synchronizer settle, then press and hold until the state leaves 'from'.
  task automatic press(input logic [2:0] from, output int lat);
    ENTER_N = 1'b1;
    repeat (4) tick();
    ENTER_N = 1'b0;
    lat = 0;
    while (state_o == from && lat < 12) begin
      tick();
      lat++;
    end
    total++;
    if (state_o == from) begin
      bad++;
      $display("FAIL press_exit state got=%b want=not %b", state_o, from);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (outs !== O_INIT) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs, O_INIT); end
    reset_n = 1'b1;
    tick();
    total++;
    if (outs !== O_SETUP) begin bad++; $display("FAIL reset_to_setup got=%b want=%b", outs, O_SETUP); end
  endtask

  task automatic test_enter_start();
    int lat;
    press(3'b001, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL enter_latency got=%0d want=4", lat); end
    total++;
    if (outs !== O_START) begin bad++; $display("FAIL enter_start got=%b want=%b", outs, O_START); end
    tick();
    total++;
    if (outs !== O_PLAYF) begin bad++; $display("FAIL start_to_playf got=%b want=%b", outs, O_PLAYF); end
    repeat (100) tick();
    total++;
    if (outs !== O_PLAYF) begin bad++; $display("FAIL held_in_playf got=%b want=%b", outs, O_PLAYF); end
  endtask

  // Key is still held from the previous press: RESULT must not see a second pulse.
  task automatic test_held_key_result();
    int lat;
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    total++;
    if (outs !== O_PLAYU) begin bad++; $display("FAIL playf_to_playu got=%b want=%b", outs, O_PLAYU); end
    end_time = 1'b1;
    tick();
    end_time = 1'b0;
    total++;
    if (outs !== O_RESULT) begin bad++; $display("FAIL timeout_result got=%b want=%b", outs, O_RESULT); end
    repeat (20) tick();
    ENTER_N = 1'b1;
    repeat (10) tick();
    total++;
    if (outs !== O_RESULT) begin bad++; $display("FAIL held_key_result got=%b want=%b", outs, O_RESULT); end
    press(3'b111, lat);
    total++;
    if (outs !== O_INIT) begin bad++; $display("FAIL result_to_init got=%b want=%b", outs, O_INIT); end
    tick();
    total++;
    if (outs !== O_SETUP) begin bad++; $display("FAIL init_to_setup got=%b want=%b", outs, O_SETUP); end
  endtask

  task automatic test_round_pass();
    int lat;
    press(3'b001, lat);
    tick();
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    end_User = 1'b1;
    match    = 1'b1;
    win      = 1'b0;
    tick();
    end_User = 1'b0;
    total++;
    if (outs !== O_CHECK) begin bad++; $display("FAIL pass_check got=%b want=%b", outs, O_CHECK); end
    tick();
    total++;
    if (outs !== O_NEXT) begin bad++; $display("FAIL pass_next got=%b want=%b", outs, O_NEXT); end
    tick();
    total++;
    if (outs !== O_START) begin bad++; $display("FAIL pass_start got=%b want=%b", outs, O_START); end
    tick();
    match = 1'b0;
    total++;
    if (outs !== O_PLAYF) begin bad++; $display("FAIL pass_playf got=%b want=%b", outs, O_PLAYF); end
  endtask

  task automatic test_async_reset();
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    total++;
    if (outs !== O_PLAYU) begin bad++; $display("FAIL pre_reset_playu got=%b want=%b", outs, O_PLAYU); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (outs !== O_INIT) begin bad++; $display("FAIL async_reset got=%b want=%b", outs, O_INIT); end
    #4 reset_n = 1'b1;
    tick();
    total++;
    if (outs !== O_SETUP) begin bad++; $display("FAIL reset_release got=%b want=%b", outs, O_SETUP); end
  endtask

  task automatic test_collision();
    int lat;
    press(3'b001, lat);
    tick();
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    end_User = 1'b1;
    end_time = 1'b1;
    match    = 1'b0;
    tick();
    end_User = 1'b0;
    end_time = 1'b0;
    total++;
    if (outs !== O_CHECK) begin bad++; $display("FAIL collision_check got=%b want=%b", outs, O_CHECK); end
    tick();
    total++;
    if (outs !== O_RESULT) begin bad++; $display("FAIL mismatch_result got=%b want=%b", outs, O_RESULT); end
  endtask

  task automatic test_final_round();
    int lat;
    press(3'b111, lat);
    total++;
    if (outs !== O_INIT) begin bad++; $display("FAIL final_init got=%b want=%b", outs, O_INIT); end
    tick();
    press(3'b001, lat);
    tick();
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    end_User = 1'b1;
    match    = 1'b1;
    win      = 1'b1;
    tick();
    end_User = 1'b0;
    total++;
    if (outs !== O_CHECK) begin bad++; $display("FAIL final_check got=%b want=%b", outs, O_CHECK); end
    tick();
    match = 1'b0;
    win   = 1'b0;
    total++;
    if (outs !== O_RESULT) begin bad++; $display("FAIL final_result got=%b want=%b", outs, O_RESULT); end
  endtask

  task automatic test_restart();
`ifdef GENIUS_AUTO_RESTART_EN
    repeat (7) tick();
    total++;
    if (outs !== O_RESULT) begin bad++; $display("FAIL dwell_hold got=%b want=%b", outs, O_RESULT); end
    tick();
    total++;
    if (outs !== O_INIT) begin bad++; $display("FAIL dwell_exit got=%b want=%b", outs, O_INIT); end
`else
    repeat (1000) tick();
    total++;
    if (outs !== O_RESULT) begin bad++; $display("FAIL no_auto_restart got=%b want=%b", outs, O_RESULT); end
`endif
  endtask

  initial begin
    test_reset();
    test_enter_start();
    test_held_key_result();
    test_round_pass();
    test_async_reset();
    test_collision();
    test_final_round();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
